// File: rtl/dma_ctrl.sv
// ---------------------------------------------------------------------------
// dma_ctrl
//
// Multi-channel DMA controller. Each of N_CH channels holds a source address,
// destination address, word count and addressing mode. A single bus engine
// moves one word at a time (read, latency cycle, write), picking the next
// channel round-robin. Each channel pulses its own ddone bit for one cycle
// when its last word has been written.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cfg_we                one-cycle program strobe
//   cfg_ch                channel being programmed
//   cfg_src, cfg_dst      start addresses for the channel
//   cfg_cnt               number of words (0 completes immediately)
//   cfg_mode              00 inc/inc, 01 fixed src, 10 fixed dst, 11 as 00
//   bus_grant             bus available; low holds off new word transfers
//   rdata                 read data, valid the cycle after read is sampled
//   address, read, write  bus address and strobes
//   wdata                 bus write data
//   ch_busy               per-channel "words pending"
//   ddone                 per-channel one-cycle completion pulse
// ---------------------------------------------------------------------------
module dma_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 6,
    parameter int N_CH   = 4,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [CNT_W-1:0]  cfg_cnt,
    input  logic [1:0]        cfg_mode,
    input  logic              bus_grant,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] wdata,
    output logic [N_CH-1:0]   ch_busy,
    output logic [N_CH-1:0]   ddone
);

    typedef enum logic [1:0] {
        ARB = 2'd0,
        RD  = 2'd1,
        LAT = 2'd2,
        WR  = 2'd3
    } state_t;

    localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] src_r  [N_CH];
    logic [ADDR_W-1:0] dst_r  [N_CH];
    logic [CNT_W-1:0]  cnt_r  [N_CH];
    logic [1:0]        mode_r [N_CH];
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   ddone_r;

    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   winner;
    logic              found;
    logic [CH_W:0]     scan_sum;
    logic [CH_W-1:0]   scan_ch;
    logic [DATA_W-1:0] data_r;
    logic              cfg_ok;
    logic              grant_word;

    // A program write is only taken for an existing, idle channel; a write to
    // a busy channel (including one finishing its last word this cycle) is
    // dropped so its in-flight block is never disturbed.
    assign cfg_ok     = cfg_we && ({1'b0, cfg_ch} < N_CH_EXT) && !busy[cfg_ch];
    assign grant_word = (state == ARB) && bus_grant && found;

    assign ch_busy = busy;
    assign ddone   = ddone_r;

    // Round-robin search: scan channels starting at rr_ptr, wrapping modulo
    // N_CH, and take the first busy one.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        scan_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_sum = {1'b0, rr_ptr} + (CH_W + 1)'(i);
            if (scan_sum >= N_CH_EXT) begin
                scan_sum = scan_sum - N_CH_EXT;
            end
            scan_ch = scan_sum[CH_W-1:0];
            if (!found && busy[scan_ch]) begin
                found  = 1'b1;
                winner = scan_ch;
            end
        end
    end

    // State register for the word-transfer engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: bus_grant only matters in ARB, so once a word has
    // been started it always runs through RD, LAT and WR.
    always_comb begin
        next_state = state;
        case (state)
            ARB:     if (bus_grant && found) next_state = RD;
            RD:      next_state = LAT;
            LAT:     next_state = WR;
            WR:      next_state = ARB;
            default: next_state = ARB;
        endcase
    end

    // Bus outputs are driven only while a word is in flight and are forced
    // to zero otherwise, so read and write can never overlap.
    always_comb begin
        address = '0;
        wdata   = '0;
        read    = 1'b0;
        write   = 1'b0;
        case (state)
            RD, LAT: begin
                read    = 1'b1;
                address = src_r[cur_ch];
            end
            WR: begin
                write   = 1'b1;
                address = dst_r[cur_ch];
                wdata   = data_r;
            end
            default: ;
        endcase
    end

    // Winner latch, round-robin pointer and read-data capture. The pointer
    // moves to the channel after the one just granted, giving one word per
    // grant to each busy channel in turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_ch <= '0;
            rr_ptr <= '0;
            data_r <= '0;
        end else begin
            if (grant_word) begin
                cur_ch <= winner;
                rr_ptr <= (winner == LAST_CH) ? '0 : winner + CH_W'(1);
            end
            if (state == LAT) begin
                data_r <= rdata;
            end
        end
    end

    // Channel registers. Leaving WR retires one word of the current channel
    // and advances its addresses according to its mode; the last word clears
    // busy and raises ddone for the following cycle. A zero-length program
    // raises ddone directly without ever becoming busy. The WR update and a
    // program write never target the same channel because the current
    // channel is busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= '0;
            ddone_r <= '0;
            for (int i = 0; i < N_CH; i++) begin
                src_r[i]  <= '0;
                dst_r[i]  <= '0;
                cnt_r[i]  <= '0;
                mode_r[i] <= '0;
            end
        end else begin
            ddone_r <= '0;
            if (state == WR) begin
                cnt_r[cur_ch] <= cnt_r[cur_ch] - CNT_W'(1);
                if (mode_r[cur_ch] != 2'b01) begin
                    src_r[cur_ch] <= src_r[cur_ch] + ADDR_W'(1);
                end
                if (mode_r[cur_ch] != 2'b10) begin
                    dst_r[cur_ch] <= dst_r[cur_ch] + ADDR_W'(1);
                end
                if (cnt_r[cur_ch] == CNT_W'(1)) begin
                    busy[cur_ch]    <= 1'b0;
                    ddone_r[cur_ch] <= 1'b1;
                end
            end
            if (cfg_ok) begin
                if (cfg_cnt == '0) begin
                    ddone_r[cfg_ch] <= 1'b1;
                end else begin
                    src_r[cfg_ch]  <= cfg_src;
                    dst_r[cfg_ch]  <= cfg_dst;
                    cnt_r[cfg_ch]  <= cfg_cnt;
                    mode_r[cfg_ch] <= cfg_mode;
                    busy[cfg_ch]   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_ctrl
//
// Bench for dma_ctrl with four channels. A transaction-level model keeps
// each channel as a block descriptor and serves words round-robin, pushing
// the expected reads, writes and completions into queues. A monitor on the
// falling clock edge pops and compares whenever the DUT shows bus activity
// or a ddone pulse. A simple memory answers reads one cycle later.
// ---------------------------------------------------------------------------
module tb_dma_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 6;
    localparam int N_CH   = 4;
    localparam int CH_W   = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [ADDR_W-1:0] cfg_src = '0;
    logic [ADDR_W-1:0] cfg_dst = '0;
    logic [CNT_W-1:0]  cfg_cnt = '0;
    logic [1:0]        cfg_mode = '0;
    logic              bus_grant = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [N_CH-1:0]   ch_busy;
    logic [N_CH-1:0]   ddone;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [31:0] exp_rd [$];
    wr_t         exp_wr [$];
    int          exp_done [$];
    int          wr_cycles [$];
    wr_t         mon_e;

    logic [31:0] m_src  [N_CH];
    logic [31:0] m_dst  [N_CH];
    int          m_cnt  [N_CH];
    int          m_mode [N_CH];
    bit          m_busy [N_CH];
    int          m_ptr = 0;

    dma_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W),
        .N_CH  (N_CH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_src  (cfg_src),
        .cfg_dst  (cfg_dst),
        .cfg_cnt  (cfg_cnt),
        .cfg_mode (cfg_mode),
        .bus_grant(bus_grant),
        .rdata    (rdata),
        .address  (address),
        .read     (read),
        .write    (write),
        .wdata    (wdata),
        .ch_busy  (ch_busy),
        .ddone    (ddone)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Background contents for locations never written.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Bus memory: writes land on the edge, read data appears one cycle after
    // the read strobe is sampled.
    always @(posedge clk) begin
        if (write) bus_mem[address] = wdata;
        if (read) rdata <= memRead(address);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setMem(input logic [31:0] a, input logic [31:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Model: serve one word from the next busy channel in round-robin order.
    task automatic modelServe();
        int w;
        logic [31:0] d;
        w = -1;
        for (int k = 0; k < N_CH; k++) begin
            if (w < 0 && m_busy[(m_ptr + k) % N_CH]) w = (m_ptr + k) % N_CH;
        end
        if (w >= 0) begin
            d = refRead(m_src[w]);
            exp_rd.push_back(m_src[w]);
            exp_rd.push_back(m_src[w]);
            exp_wr.push_back('{a: m_dst[w], d: d});
            ref_mem[m_dst[w]] = d;
            m_cnt[w]--;
            if (m_mode[w] != 1) m_src[w] = m_src[w] + 32'd1;
            if (m_mode[w] != 2) m_dst[w] = m_dst[w] + 32'd1;
            if (m_cnt[w] == 0) begin
                m_busy[w] = 1'b0;
                exp_done.push_back(w);
            end
            m_ptr = (w + 1) % N_CH;
        end
    endtask

    task automatic modelDrain();
        bit any;
        do begin
            any = 1'b0;
            for (int k = 0; k < N_CH; k++) if (m_busy[k]) any = 1'b1;
            if (any) modelServe();
        end while (any);
    endtask

    task automatic modelClear();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        for (int k = 0; k < N_CH; k++) m_busy[k] = 1'b0;
        m_ptr = 0;
    endtask

    // Program one channel for one cycle; the model mirrors the accept/ignore
    // rule so ignored writes leave its descriptor untouched.
    task automatic applyStimulus(input int ch, input logic [31:0] src, input logic [31:0] dst,
                                 input int cnt, input int mode);
        if (!m_busy[ch]) begin
            if (cnt == 0) begin
                exp_done.push_back(ch);
            end else begin
                m_src[ch]  = src;
                m_dst[ch]  = dst;
                m_cnt[ch]  = cnt;
                m_mode[ch] = mode;
                m_busy[ch] = 1'b1;
            end
        end
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_src  = src;
        cfg_dst  = dst;
        cfg_cnt  = CNT_W'(cnt);
        cfg_mode = 2'(mode);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ch_busy"}, ch_busy, 0);
        checkOutput({tag, "_ddone"}, ddone, 0);
        checkOutput({tag, "_read"}, read, 0);
        checkOutput({tag, "_write"}, write, 0);
        checkOutput({tag, "_address"}, address, 0);
        checkOutput({tag, "_wdata"}, wdata, 0);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        cfg_we = 1'b0;
        repeat (2) step();
        modelClear();
        checkResetState("reset");
        reset = 1'b0;
    endtask

    task automatic waitIdle(input int maxc);
        int ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            if (ch_busy == 0) begin
                ok = 1;
                break;
            end
            step();
        end
        checkOutput("idle_reached", ok, 1);
        repeat (3) step();
        checkOutput("rd_queue_left", exp_rd.size(), 0);
        checkOutput("wr_queue_left", exp_wr.size(), 0);
        checkOutput("done_queue_left", exp_done.size(), 0);
    endtask

    // Monitor: compares every bus cycle and every ddone pulse against the
    // expectation queues, and checks idle outputs are zero.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rw_exclusive", read && write, 0);
            if (!read && !write) begin
                checkOutput("idle_address", address, 0);
                checkOutput("idle_wdata", wdata, 0);
            end
            if (read) begin
                if (exp_rd.size() == 0) checkOutput("unexpected_read", address, 64'hDEAD);
                else checkOutput("read_address", address, exp_rd.pop_front());
            end
            if (write) begin
                wr_cycles.push_back(cycle);
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", address, 64'hDEAD);
                end else begin
                    mon_e = exp_wr.pop_front();
                    checkOutput("write_address", address, mon_e.a);
                    checkOutput("write_data", wdata, mon_e.d);
                end
            end
            if (ddone != 0) begin
                checkOutput("ddone_onehot", $countones(ddone), 1);
                if (exp_done.size() == 0) checkOutput("unexpected_ddone", ddone, 0);
                else checkOutput("ddone_channel", ddone, 64'(1) << exp_done.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int got;

        // Single-word copy with cycle-exact timing.
        resetDut();
        setMem(32'd1, 32'h0f);
        bus_grant = 1'b1;
        applyStimulus(0, 32'd1, 32'd70, 1, 0);
        modelDrain();
        checkOutput("c0_busy", ch_busy, 4'b0001);
        checkOutput("c0_read", read, 0);
        step();
        checkOutput("c1_read", read, 1);
        checkOutput("c1_address", address, 1);
        step();
        checkOutput("c2_read", read, 1);
        checkOutput("c2_address", address, 1);
        step();
        checkOutput("c3_write", write, 1);
        checkOutput("c3_address", address, 70);
        checkOutput("c3_wdata", wdata, 32'h0f);
        step();
        checkOutput("c4_ddone", ddone, 4'b0001);
        checkOutput("c4_write", write, 0);
        checkOutput("c4_busy", ch_busy, 0);
        step();
        checkOutput("c5_ddone", ddone, 0);
        checkOutput("mem70", memRead(32'd70), 32'h0f);
        waitIdle(20);

        // Block copy, 4 cycles per word.
        setMem(32'd64, 32'd4);
        setMem(32'd65, 32'd5);
        setMem(32'd66, 32'd6);
        wr_cycles.delete();
        applyStimulus(0, 32'd64, 32'd70, 3, 0);
        modelDrain();
        waitIdle(40);
        checkOutput("block_writes", wr_cycles.size(), 3);
        if (wr_cycles.size() == 3) begin
            checkOutput("block_gap1", wr_cycles[1] - wr_cycles[0], 4);
            checkOutput("block_gap2", wr_cycles[2] - wr_cycles[1], 4);
        end
        checkOutput("mem70_block", memRead(32'd70), 4);
        checkOutput("mem71_block", memRead(32'd71), 5);
        checkOutput("mem72_block", memRead(32'd72), 6);

        // Fixed-source and fixed-destination modes.
        applyStimulus(1, 32'd32, 32'd100, 3, 1);
        modelDrain();
        waitIdle(40);
        applyStimulus(2, 32'd40, 32'd110, 3, 2);
        modelDrain();
        waitIdle(40);
        checkOutput("mode10_dst", memRead(32'd110), dflt(32'd42));

        // Grant low holds the engine in arbitration.
        bus_grant = 1'b0;
        applyStimulus(0, 32'd5, 32'd90, 2, 0);
        modelDrain();
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("nogrant_quiet", {read, write}, 0);
        end
        bus_grant = 1'b1;
        waitIdle(40);

        // Reprogramming a busy channel is ignored.
        bus_grant = 1'b0;
        applyStimulus(2, 32'd50, 32'd120, 2, 0);
        applyStimulus(2, 32'd0, 32'd0, 5, 3);
        modelDrain();
        bus_grant = 1'b1;
        waitIdle(40);
        checkOutput("reprog_dst", memRead(32'd121), dflt(32'd51));

        // Zero-length program: ddone next cycle, no bus activity.
        applyStimulus(3, 32'd7, 32'd8, 0, 0);
        checkOutput("cnt0_ddone", ddone, 4'b1000);
        checkOutput("cnt0_busy", ch_busy, 0);
        checkOutput("cnt0_read", read, 0);
        step();
        checkOutput("cnt0_ddone_off", ddone, 0);
        waitIdle(10);

        // Two channels alternate from a fresh round-robin pointer.
        resetDut();
        bus_grant = 1'b0;
        applyStimulus(0, 32'd64, 32'd75, 2, 0);
        applyStimulus(1, 32'd66, 32'd78, 2, 0);
        modelDrain();
        bus_grant = 1'b1;
        waitIdle(60);

        // Idle channel programmed mid-transfer joins at the next arbitration.
        resetDut();
        bus_grant = 1'b0;
        applyStimulus(0, 32'd20, 32'd84, 2, 0);
        modelServe();
        bus_grant = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read) begin
                got = 1;
                break;
            end
        end
        checkOutput("join_read_seen", got, 1);
        step();
        applyStimulus(1, 32'd24, 32'd88, 1, 0);
        modelDrain();
        waitIdle(60);

        // Source address wrap.
        applyStimulus(0, 32'hFFFF_FFFF, 32'd200, 2, 0);
        modelDrain();
        waitIdle(40);

        // Reset during LAT aborts the word.
        bus_grant = 1'b0;
        applyStimulus(0, 32'd10, 32'd80, 3, 0);
        modelDrain();
        bus_grant = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read) begin
                got = 1;
                break;
            end
        end
        checkOutput("abort_read_seen", got, 1);
        @(negedge clk);
        reset = 1'b1;
        step();
        checkResetState("abort");
        modelClear();
        step();
        reset = 1'b0;
        repeat (8) step();
        checkOutput("abort_no_write", bus_mem.exists(32'd80), 0);
        waitIdle(10);

        // Randomised batches with a toggling grant.
        for (int b = 0; b < 10; b++) begin
            bus_grant = 1'b0;
            for (int k = 0; k < 5; k++) begin
                applyStimulus($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                              $urandom_range(0, 4), $urandom_range(0, 3));
            end
            modelDrain();
            for (int i = 0; i < 3000; i++) begin
                bus_grant = ($urandom_range(0, 3) != 0);
                step();
                if (ch_busy == 0) break;
            end
            bus_grant = 1'b1;
            waitIdle(40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
